// File: rtl/bpred_resolve_queue.sv
// In-order resolve queue for the gshare predictor: tracks in-flight branches, issues PHT updates,
// and drives flush/GHR recovery on a mispredict. Optional counters under BPRED_RESOLVE_STATS_EN.
module bpred_resolve_queue #(
  parameter int DEPTH          = 8,
  parameter int GHR_WIDTH      = 8,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [GHR_WIDTH-1:0]   push_pc,
  input  logic [GHR_WIDTH-1:0]   push_ghr,
  input  logic                   push_pred,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic                   res_taken,
  output logic                   upd_valid,
  output logic [GHR_WIDTH-1:0]   upd_index,
  output logic                   upd_taken,
  output logic                   mispredict,
  output logic [GHR_WIDTH-1:0]   restore_ghr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   fsm_state
`ifdef BPRED_RESOLVE_STATS_EN
  ,
  output logic [15:0]            stat_resolved,
  output logic [15:0]            stat_mispred
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  // Handshake: a transfer fires on the rising clock edge where valid && ready are both high.
  // Ready never depends on valid; fetch/execute must hold their payload until it fires.

  state_t                 state, state_nxt;
  logic [RW-1:0]          rec_cnt;
  logic [AW:0]            wr_ptr, rd_ptr;
  logic [GHR_WIDTH-1:0]   mem_pc  [DEPTH];
  logic [GHR_WIDTH-1:0]   mem_ghr [DEPTH];
  logic                   mem_pred [DEPTH];
  logic                   full, empty;
  logic                   push_fire, res_fire, mis_fire;
  logic [GHR_WIDTH-1:0]   head_pc, head_ghr;
  logic                   head_pred;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign head_pc   = mem_pc[rd_ptr[AW-1:0]];
  assign head_ghr  = mem_ghr[rd_ptr[AW-1:0]];
  assign head_pred = mem_pred[rd_ptr[AW-1:0]];
  assign push_fire = push_valid && push_ready;
  assign res_fire  = res_valid && res_ready;
  assign mis_fire  = res_fire && (res_taken != head_pred);

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mis_fire) state_nxt = RECOVER;
      RECOVER: if (rec_cnt == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    push_ready = (state == RUN) && !full;
    res_ready  = (state == RUN) && !empty;
    fsm_state  = state;
  end

  // Loaded one short so RECOVER lasts exactly RECOVER_CYCLES cycles including the entry cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       rec_cnt <= '0;
    else if (mis_fire)               rec_cnt <= RW'(RECOVER_CYCLES - 1);
    else if (state == RECOVER && rec_cnt != '0) rec_cnt <= rec_cnt - RW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (mis_fire) begin
      // Flush also drops a push accepted in the same cycle.
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (res_fire)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_pc[wr_ptr[AW-1:0]]   <= push_pc;
      mem_ghr[wr_ptr[AW-1:0]]  <= push_ghr;
      mem_pred[wr_ptr[AW-1:0]] <= push_pred;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid   <= 1'b0;
      upd_index   <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      restore_ghr <= '0;
    end else begin
      upd_valid  <= res_fire;
      mispredict <= mis_fire;
      if (res_fire) begin
        upd_index <= head_pc ^ head_ghr;
        upd_taken <= res_taken;
      end
      if (mis_fire) restore_ghr <= {head_ghr[GHR_WIDTH-2:0], res_taken};
    end
  end

`ifdef BPRED_RESOLVE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (res_fire && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
      if (mis_fire && stat_mispred  != 16'hFFFF) stat_mispred  <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Directed bench for bpred_resolve_queue: hand-computed expectations checked with immediate asserts.
module tb_bpred_resolve_queue;
  logic       clk;
  logic       reset;
  logic       push_valid, push_ready, push_pred;
  logic [7:0] push_pc, push_ghr;
  logic       res_valid, res_ready, res_taken;
  logic       upd_valid, upd_taken, mispredict;
  logic [7:0] upd_index, restore_ghr;
  logic [3:0] count;
  logic       fsm_state;
`ifdef BPRED_RESOLVE_STATS_EN
  logic [15:0] stat_resolved, stat_mispred;
`endif

  int passed = 0;
  int total  = 0;

  bpred_resolve_queue #(.DEPTH(8), .GHR_WIDTH(8), .RECOVER_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_ghr(push_ghr), .push_pred(push_pred),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .mispredict(mispredict), .restore_ghr(restore_ghr), .count(count),
    .fsm_state(fsm_state)
`ifdef BPRED_RESOLVE_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_push(input logic v, input logic [7:0] pc, input logic [7:0] ghr, input logic pred);
    push_valid = v;
    push_pc    = pc;
    push_ghr   = ghr;
    push_pred  = pred;
  endtask

  initial begin
    reset = 1'b1;
    set_push(1'b0, 8'h00, 8'h00, 1'b0);
    res_valid = 1'b0;
    res_taken = 1'b0;
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_index", upd_index, 0);
    chk("rst_upd_taken", upd_taken, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_restore", restore_ghr, 0);
    chk("rst_state", fsm_state, 0);
    #2 reset = 1'b0;
    tick();
    chk("rst_push_ready", push_ready, 1);
    chk("rst_res_ready", res_ready, 0);

    // three correct taken predictions
    set_push(1'b1, 8'h10, 8'h01, 1'b1); tick();
    set_push(1'b1, 8'h20, 8'h01, 1'b1); tick();
    set_push(1'b1, 8'h30, 8'h01, 1'b1); tick();
    set_push(1'b0, 8'h00, 8'h00, 1'b0);
    chk("t1_count3", count, 3);
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    chk("t1_upd_valid0", upd_valid, 1);
    chk("t1_idx0", upd_index, 8'h11);
    chk("t1_taken0", upd_taken, 1);
    chk("t1_misp0", mispredict, 0);
    tick();
    chk("t1_idx1", upd_index, 8'h21);
    chk("t1_misp1", mispredict, 0);
    tick();
    res_valid = 1'b0;
    chk("t1_idx2", upd_index, 8'h31);
    chk("t1_misp2", mispredict, 0);
    chk("t1_count0", count, 0);
    tick();
    chk("t1_upd_idle", upd_valid, 0);
    chk("t1_idx_hold", upd_index, 8'h31);

    // fill to DEPTH, 9th push held until a resolve frees a slot
    for (int i = 0; i < 8; i++) begin
      set_push(1'b1, 8'(i), 8'h00, 1'b0);
      tick();
    end
    set_push(1'b1, 8'h88, 8'h00, 1'b0);
    chk("t2_full_count", count, 8);
    chk("t2_full_ready", push_ready, 0);
    tick();
    chk("t2_held_count", count, 8);
    res_valid = 1'b1; res_taken = 1'b0;
    chk("t2_res_ready_full", res_ready, 1);
    tick();
    res_valid = 1'b0;
    chk("t2_after_pop", count, 7);
    chk("t2_ready_again", push_ready, 1);
    chk("t2_pop_idx", upd_index, 8'h00);
    tick();
    set_push(1'b0, 8'h00, 8'h00, 1'b0);
    chk("t2_ninth_in", count, 8);
    res_valid = 1'b1; res_taken = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    res_valid = 1'b0;
    chk("t2_drain_idx", upd_index, 8'h88);
    chk("t2_drain_count", count, 0);
    chk("t2_drain_misp", mispredict, 0);

    // mispredict flushes younger entries and stalls 2 cycles
    set_push(1'b1, 8'h40, 8'hA5, 1'b1); tick();
    set_push(1'b1, 8'h50, 8'h00, 1'b0); tick();
    set_push(1'b1, 8'h60, 8'h00, 1'b0); tick();
    set_push(1'b0, 8'h00, 8'h00, 1'b0);
    chk("t3_count3", count, 3);
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    chk("t3_misp", mispredict, 1);
    chk("t3_restore", restore_ghr, 8'h4A);
    chk("t3_upd_valid", upd_valid, 1);
    chk("t3_idx", upd_index, 8'hE5);
    chk("t3_taken", upd_taken, 0);
    chk("t3_count0", count, 0);
    chk("t3_push_rdy0", push_ready, 0);
    chk("t3_res_rdy0", res_ready, 0);
    chk("t3_state_rec", fsm_state, 1);
    tick();
    chk("t3_misp_pulse", mispredict, 0);
    chk("t3_push_rdy1", push_ready, 0);
    chk("t3_upd_idle", upd_valid, 0);
    tick();
    chk("t3_push_rdy2", push_ready, 1);
    chk("t3_restore_hold", restore_ghr, 8'h4A);

    // push accepted in the mispredict cycle is discarded
    set_push(1'b1, 8'h70, 8'h0F, 1'b0); tick();
    set_push(1'b1, 8'h71, 8'h00, 1'b0);
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    set_push(1'b0, 8'h00, 8'h00, 1'b0);
    res_valid = 1'b0;
    chk("t4_misp", mispredict, 1);
    chk("t4_restore", restore_ghr, 8'h1F);
    chk("t4_idx", upd_index, 8'h7F);
    chk("t4_count0", count, 0);
    tick();
    tick();
    chk("t4_push_rdy", push_ready, 1);
    chk("t4_empty", res_ready, 0);
    chk("t4_count_after", count, 0);

    // resolve against an empty queue is refused
    res_valid = 1'b1; res_taken = 1'b1;
    chk("t5_empty_res_rdy", res_ready, 0);
    tick();
    res_valid = 1'b0;
    chk("t5_no_upd", upd_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      set_push(1'b1, 8'(i), 8'h00, 1'b1);
      tick();
    end
    chk("t5_count4", count, 4);
    set_push(1'b1, 8'h05, 8'h00, 1'b1);
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    set_push(1'b0, 8'h00, 8'h00, 1'b0);
    res_valid = 1'b0;
    chk("t5_count_same", count, 4);
    chk("t5_idx", upd_index, 8'h01);
    chk("t5_misp", mispredict, 0);

    // reset during RECOVER with a push pending
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    set_push(1'b1, 8'h99, 8'h33, 1'b1);
    chk("t6_in_recover", fsm_state, 1);
    chk("t6_idx", upd_index, 8'h02);
`ifdef BPRED_RESOLVE_STATS_EN
    chk("t6_stat_res", stat_resolved, 16);
    chk("t6_stat_mis", stat_mispred, 3);
`endif
    reset = 1'b1;
    #1;
    chk("t6_rst_state", fsm_state, 0);
    chk("t6_rst_misp", mispredict, 0);
    chk("t6_rst_upd_valid", upd_valid, 0);
    chk("t6_rst_idx", upd_index, 0);
    chk("t6_rst_restore", restore_ghr, 0);
    chk("t6_rst_count", count, 0);
`ifdef BPRED_RESOLVE_STATS_EN
    chk("t6_rst_stat_res", stat_resolved, 0);
    chk("t6_rst_stat_mis", stat_mispred, 0);
`endif
    set_push(1'b0, 8'h00, 8'h00, 1'b0);
    #2 reset = 1'b0;
    tick();
    chk("t6_push_rdy", push_ready, 1);
    chk("t6_post_misp", mispredict, 0);
    chk("t6_post_upd", upd_valid, 0);

    // reset with a non-empty queue
    set_push(1'b1, 8'h9A, 8'h00, 1'b0); tick(); tick();
    set_push(1'b0, 8'h00, 8'h00, 1'b0);
    chk("t7_count2", count, 2);
    reset = 1'b1;
    #1;
    chk("t7_rst_count", count, 0);
    #2 reset = 1'b0;
    tick();
    chk("t7_res_rdy", res_ready, 0);
    chk("t7_upd", upd_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
